alu_tile_host_injector: RTL and testbench

Host-side endpoint for the ALU tile host port. It drives the tile's host_in_a/host_in_b/host_in_ctrl/host_in_valid and collects host_out_a/host_out_valid. Commands come from a valid/ready stream and are issued to the tile under credit-based flow control. Results are buffered in an in-order response FIFO with backpressure, and a timeout watchdog raises an error if the tile stops responding. It sits between the MPI/DPI host bridge and one tile wrapper's host port.

---
 rtl/alu_tile_host_injector.sv | 155 +++++++++++++++
 tb/tb_alu_tile_host_injector.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_tile_host_injector.sv
// Host-side injector for one ALU tile host port: credit-limited command issue,
// in-order response FIFO, timeout watchdog. Define ALU_HOST_STATS_EN for issue/completion counters.
module alu_tile_host_injector #(
   parameter int RSP_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
   // ready never depends on valid, and the offering side holds its payload until accepted.
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_a,
   input  logic [63:0] cmd_b,
   input  logic [15:0] cmd_ctrl,
   output logic [63:0] host_in_a,
   output logic [63:0] host_in_b,
   output logic [15:0] host_in_ctrl,
   output logic        host_in_valid,
   input  logic [63:0] host_out_a,
   input  logic        host_out_valid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic [4:0]  outstanding,
   output logic        err_timeout,
   output logic        err_unexpected,
   input  logic        err_clear,
   output logic [1:0]  state_dbg
`ifdef ALU_HOST_STATS_EN
   ,
   output logic [31:0] stat_issued,
   output logic [31:0] stat_completed
`endif
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [63:0]      mem [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic [WD_W-1:0]  wd_count;
   logic [4:0]       outstanding_next;
   logic [5:0]       credit_sum;
   logic             accept, pop, push, full, drop, late_rsp, retire, timeout_hit;

   // Credits cover both in-flight commands and buffered results so a push can never overflow.
   assign credit_sum = {1'b0, outstanding} + 6'(fifo_count);
   assign cmd_ready  = !rst && (state != ERROR) && (outstanding < 5'(MAX_OUTSTANDING))
                       && (credit_sum < 6'(RSP_DEPTH));
   assign accept     = cmd_valid && cmd_ready;

   assign full      = (fifo_count == CNT_W'(RSP_DEPTH));
   assign rsp_valid = (fifo_count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign push      = host_out_valid && (!full || pop);
   assign drop      = host_out_valid && full && !pop;
   assign rsp_data  = rsp_valid ? mem[rd_ptr] : 64'd0;

   assign late_rsp    = host_out_valid && (outstanding == 5'd0);
   assign retire      = host_out_valid && (outstanding != 5'd0);
   // Fire on the edge where the watchdog would step to TIMEOUT_CYCLES-1.
   assign timeout_hit = (outstanding != 5'd0) && !host_out_valid
                        && (wd_count == WD_W'(TIMEOUT_CYCLES - 2));

   assign state_dbg = state;

   always_comb begin
      outstanding_next = outstanding;
      if (timeout_hit) begin
         outstanding_next = 5'd0;
      end else if (accept && !retire) begin
         outstanding_next = outstanding + 5'd1;
      end else if (!accept && retire) begin
         outstanding_next = outstanding - 5'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (outstanding_next != 5'd0) state_next = BUSY;
         BUSY: begin
            if (timeout_hit)                    state_next = ERROR;
            else if (outstanding_next == 5'd0)  state_next = IDLE;
         end
         ERROR:   if (err_clear) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         outstanding    <= 5'd0;
         host_in_valid  <= 1'b0;
         host_in_a      <= 64'd0;
         host_in_b      <= 64'd0;
         host_in_ctrl   <= 16'd0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
         wd_count       <= '0;
         err_timeout    <= 1'b0;
         err_unexpected <= 1'b0;
      end else begin
         state         <= state_next;
         outstanding   <= outstanding_next;
         host_in_valid <= accept;
         if (accept) begin
            host_in_a    <= cmd_a;
            host_in_b    <= cmd_b;
            host_in_ctrl <= cmd_ctrl;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (!push && pop) fifo_count <= fifo_count - 1'b1;
         if (host_out_valid || (outstanding == 5'd0) || timeout_hit) wd_count <= '0;
         else                                                        wd_count <= wd_count + 1'b1;
         // A flag being set in the same cycle as err_clear keeps the flag.
         if (timeout_hit)    err_timeout <= 1'b1;
         else if (err_clear) err_timeout <= 1'b0;
         if (late_rsp || drop) err_unexpected <= 1'b1;
         else if (err_clear)   err_unexpected <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= host_out_a;
   end

`ifdef ALU_HOST_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued    <= 32'd0;
         stat_completed <= 32'd0;
      end else begin
         if (accept && (stat_issued != 32'hFFFF_FFFF)) stat_issued <= stat_issued + 32'd1;
         if (push && (stat_completed != 32'hFFFF_FFFF)) stat_completed <= stat_completed + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_tile_host_injector.sv
// Bench for alu_tile_host_injector: directed scenarios then random traffic, every cycle
// compared against a transaction-level model (queue of pending results, credit arithmetic).
module tb_alu_tile_host_injector;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
   localparam int TO    = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [63:0] cmd_a, cmd_b;
   logic [15:0] cmd_ctrl;
   logic [63:0] host_in_a, host_in_b;
   logic [15:0] host_in_ctrl;
   logic        host_in_valid;
   logic [63:0] host_out_a;
   logic        host_out_valid;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic [4:0]  outstanding;
   logic        err_timeout, err_unexpected, err_clear;
   logic [1:0]  state_dbg;
`ifdef ALU_HOST_STATS_EN
   logic [31:0] stat_issued, stat_completed;
`endif

   always #5 clk = ~clk;

   alu_tile_host_injector #(
      .RSP_DEPTH(DEPTH),
      .MAX_OUTSTANDING(MAXO),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_a(cmd_a),
      .cmd_b(cmd_b),
      .cmd_ctrl(cmd_ctrl),
      .host_in_a(host_in_a),
      .host_in_b(host_in_b),
      .host_in_ctrl(host_in_ctrl),
      .host_in_valid(host_in_valid),
      .host_out_a(host_out_a),
      .host_out_valid(host_out_valid),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .outstanding(outstanding),
      .err_timeout(err_timeout),
      .err_unexpected(err_unexpected),
      .err_clear(err_clear),
      .state_dbg(state_dbg)
`ifdef ALU_HOST_STATS_EN
      ,
      .stat_issued(stat_issued),
      .stat_completed(stat_completed)
`endif
   );

   int n_err    = 0;
   int n_checks = 0;

   // Reference model state
   int          m_out, m_wd;
   bit          m_eto, m_eun, m_hiv;
   logic [63:0] m_ha, m_hb;
   logic [15:0] m_hc;
   logic [63:0] exp_q[$];
   int unsigned m_iss, m_cmp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_ready();
      return !m_eto && (m_out < MAXO) && ((m_out + exp_q.size()) < DEPTH);
   endfunction

   task automatic model_reset();
      m_out = 0; m_wd = 0; m_eto = 0; m_eun = 0; m_hiv = 0;
      m_ha = '0; m_hb = '0; m_hc = '0;
      exp_q.delete();
      m_iss = 0; m_cmp = 0;
   endtask

   task automatic model_step(input bit cv, input logic [63:0] a, input logic [63:0] b,
                             input logic [15:0] c, input bit ov, input logic [63:0] oa,
                             input bit rr, input bit ec);
      bit acc, pop, timeout, unexp;
      int nwd;
      acc     = cv && model_ready();
      pop     = rr && (exp_q.size() > 0);
      nwd     = (ov || m_out == 0) ? 0 : m_wd + 1;
      timeout = (m_out > 0) && (nwd == TO - 1);
      unexp   = ov && (m_out == 0);
      if (pop) void'(exp_q.pop_front());
      if (ov) begin
         if (exp_q.size() < DEPTH) begin
            exp_q.push_back(oa);
            m_cmp++;
         end else begin
            unexp = 1;
         end
      end
      if (timeout) m_out = 0;
      else         m_out = m_out + (acc ? 1 : 0) - ((ov && m_out > 0) ? 1 : 0);
      m_wd  = timeout ? 0 : nwd;
      m_eto = timeout ? 1'b1 : (ec ? 1'b0 : m_eto);
      m_eun = unexp ? 1'b1 : (ec ? 1'b0 : m_eun);
      m_hiv = acc;
      if (acc) begin
         m_ha = a; m_hb = b; m_hc = c;
         m_iss++;
      end
   endtask

   task automatic check_all();
      chk("cmd_ready", 64'(cmd_ready), 64'(model_ready()));
      chk("host_in_valid", 64'(host_in_valid), 64'(m_hiv));
      chk("host_in_a", host_in_a, m_ha);
      chk("host_in_b", host_in_b, m_hb);
      chk("host_in_ctrl", 64'(host_in_ctrl), 64'(m_hc));
      chk("outstanding", 64'(outstanding), 64'(m_out));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
      chk("rsp_data", rsp_data, (exp_q.size() > 0) ? exp_q[0] : 64'd0);
      chk("err_timeout", 64'(err_timeout), 64'(m_eto));
      chk("err_unexpected", 64'(err_unexpected), 64'(m_eun));
      chk("state", 64'(state_dbg), m_eto ? 64'd2 : ((m_out > 0) ? 64'd1 : 64'd0));
`ifdef ALU_HOST_STATS_EN
      chk("stat_issued", 64'(stat_issued), 64'(m_iss));
      chk("stat_completed", 64'(stat_completed), 64'(m_cmp));
`endif
   endtask

   task automatic step(input bit cv, input logic [63:0] a, input logic [63:0] b,
                       input logic [15:0] c, input bit ov, input logic [63:0] oa,
                       input bit rr, input bit ec);
      cmd_valid = cv; cmd_a = a; cmd_b = b; cmd_ctrl = c;
      host_out_valid = ov; host_out_a = oa;
      rsp_ready = rr; err_clear = ec;
      model_step(cv, a, b, c, ov, oa, rr, ec);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b0, 64'd0, rr, 1'b0);
   endtask

   task automatic respond(input logic [63:0] v);
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b1, v, 1'b0, 1'b0);
   endtask

   task automatic issue_one(input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
      int guard = 0;
      while (!cmd_ready && guard < 40) begin
         idle(1'b0);
         guard++;
      end
      chk("ready_wait", 64'(cmd_ready), 64'd1);
      step(1'b1, a, b, c, 1'b0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      cmd_valid = 0; cmd_a = '0; cmd_b = '0; cmd_ctrl = '0;
      host_out_valid = 0; host_out_a = '0; rsp_ready = 0; err_clear = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("rst_host_in_valid", 64'(host_in_valid), 64'd0);
         chk("rst_host_in_a", host_in_a, 64'd0);
         chk("rst_host_in_ctrl", 64'(host_in_ctrl), 64'd0);
         chk("rst_outstanding", 64'(outstanding), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_rsp_data", rsp_data, 64'd0);
         chk("rst_err_timeout", 64'(err_timeout), 64'd0);
         chk("rst_err_unexpected", 64'(err_unexpected), 64'd0);
`ifdef ALU_HOST_STATS_EN
         chk("rst_stat_issued", 64'(stat_issued), 64'd0);
         chk("rst_stat_completed", 64'(stat_completed), 64'd0);
`endif
      end
      model_reset();
      rst = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      model_reset();
      do_reset(3);
      chk("ready_after_reset", 64'(cmd_ready), 64'd1);

      // Single operation
      step(1'b1, 64'd5, 64'd7, 16'h0001, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("single_hiv", 64'(host_in_valid), 64'd1);
      chk("single_a", host_in_a, 64'd5);
      chk("single_out", 64'(outstanding), 64'd1);
      idle(1'b0);
      chk("single_hiv_pulse", 64'(host_in_valid), 64'd0);
      idle(1'b0);
      idle(1'b0);
      respond(64'd12);
      chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("single_rsp_data", rsp_data, 64'd12);
      chk("single_out_done", 64'(outstanding), 64'd0);
      idle(1'b1);

      // Credit limit
      step(1'b1, 64'd101, 64'd1, 16'h0010, 1'b0, 64'd0, 1'b0, 1'b0);
      step(1'b1, 64'd102, 64'd2, 16'h0011, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("credit_block", 64'(cmd_ready), 64'd0);
      step(1'b1, 64'd103, 64'd3, 16'h0012, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("credit_no_issue", 64'(host_in_valid), 64'd0);
      step(1'b1, 64'd103, 64'd3, 16'h0012, 1'b1, 64'hA1, 1'b0, 1'b0);
      chk("credit_return", 64'(cmd_ready), 64'd1);
      step(1'b1, 64'd103, 64'd3, 16'h0012, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("credit_third_issue", host_in_a, 64'd103);
      respond(64'hA2);
      respond(64'hA3);
      repeat (3) idle(1'b1);

      // FIFO backpressure
      issue_one(64'd1, 64'd0, 16'd0);
      issue_one(64'd2, 64'd0, 16'd0);
      respond(64'd1);
      respond(64'd2);
      issue_one(64'd3, 64'd0, 16'd0);
      issue_one(64'd4, 64'd0, 16'd0);
      respond(64'd3);
      respond(64'd4);
      chk("fifo_full_block", 64'(cmd_ready), 64'd0);
      for (int v = 1; v <= 4; v++) begin
         chk("fifo_order", rsp_data, 64'(v));
         idle(1'b1);
      end
      chk("fifo_drained_ready", 64'(cmd_ready), 64'd1);

      // Simultaneous issue/completion, then push+pop on a full FIFO
      issue_one(64'h50, 64'h1, 16'h2);
      step(1'b1, 64'h51, 64'h1, 16'h3, 1'b1, 64'h55, 1'b0, 1'b0);
      chk("simul_out", 64'(outstanding), 64'd1);
      respond(64'h56);
      issue_one(64'h52, 64'h1, 16'h4);
      respond(64'h57);
      issue_one(64'h53, 64'h1, 16'h5);
      respond(64'h58);
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b1, 64'h59, 1'b1, 1'b0);
      chk("full_pushpop_unexp", 64'(err_unexpected), 64'd1);
      for (int v = 'h56; v <= 'h59; v++) begin
         chk("full_pushpop_order", rsp_data, 64'(v));
         idle(1'b1);
      end
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b0, 64'd0, 1'b0, 1'b1);
      chk("clear_unexp", 64'(err_unexpected), 64'd0);

      // Timeout
      issue_one(64'hDEAD, 64'hBEEF, 16'h00FF);
      repeat (14) idle(1'b0);
      chk("timeout_not_yet", 64'(err_timeout), 64'd0);
      idle(1'b0);
      chk("timeout_set", 64'(err_timeout), 64'd1);
      chk("timeout_out", 64'(outstanding), 64'd0);
      chk("timeout_ready", 64'(cmd_ready), 64'd0);
      respond(64'hCAFE);
      chk("late_unexp", 64'(err_unexpected), 64'd1);
      chk("late_data", rsp_data, 64'hCAFE);
      idle(1'b1);
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b0, 64'd0, 1'b0, 1'b1);
      chk("clear_to", 64'(err_timeout), 64'd0);
      chk("clear_ready", 64'(cmd_ready), 64'd1);
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b1, 64'h77, 1'b0, 1'b1);
      chk("set_wins", 64'(err_unexpected), 64'd1);
      step(1'b0, 64'd0, 64'd0, 16'd0, 1'b0, 64'd0, 1'b1, 1'b1);

      // Reset mid-operation with two in flight and one buffered
      issue_one(64'h10, 64'h20, 16'h30);
      issue_one(64'h11, 64'h21, 16'h31);
      respond(64'h99);
      issue_one(64'h12, 64'h22, 16'h32);
      chk("pre_reset_out", 64'(outstanding), 64'd2);
      do_reset(1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         bit cv, ov, rr, ec;
         cv = ($urandom_range(0, 3) != 0);
         ov = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
         rr = ($urandom_range(0, 2) != 0);
         ec = m_eto ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0);
         step(cv, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
              ov, {$urandom, $urandom}, rr, ec);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
